// File: rtl/grid_ctrl_if.sv
// Request and mover-operand bundle around grid_ctrl.
// The slave modport is the controller side; the master modport is the requester/mover side.
interface grid_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_dir;
    logic [1:0] req_step;
    logic [3:0] mv_pos;
    logic [1:0] mv_step;
    logic       mv_op;
    logic [3:0] mv_out;

    modport slave (
        input  req_valid, req_dir, req_step, mv_out,
        output req_ready, mv_pos, mv_step, mv_op
    );

    modport master (
        output req_valid, req_dir, req_step, mv_out,
        input  req_ready, mv_pos, mv_step, mv_op
    );
endinterface

// File: rtl/grid_ctrl.sv
// Cursor X/Y owner: issues one move to the saturating mover, captures its registered result,
// commits it to the selected coordinate, and cross-checks it against a local reference.
module grid_ctrl #(
    parameter logic [3:0] HOME_X = 4'd0,
    parameter logic [3:0] HOME_Y = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    grid_ctrl_if.slave  bus,
    output logic [3:0]  x,
    output logic [3:0]  y,
    output logic        done,
    output logic        sat,
    output logic        err,
    output logic [1:0]  state_dbg
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready; req_ready is
    // high only in IDLE, and req_valid in any other state is ignored.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

    state_t     state_r, state_nxt;
    logic [3:0] x_r, y_r;
    logic [3:0] pos_r;
    logic [1:0] step_r;
    logic       op_r;
    logic       sel_y_r;
    logic [3:0] exp_r;
    logic       sat_exp_r;
    logic       done_r, sat_r, err_r;

    logic       accept;
    logic       commit;
    logic [3:0] sel_pos;
    logic [4:0] sum;
    logic       under;
    logic [3:0] exp_nxt;
    logic       sat_nxt;

    always_comb begin
        state_nxt = state_r;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reference result, computed at accept time from the coordinate being moved.
    always_comb begin
        sel_pos = bus.req_dir[1] ? y_r : x_r;
        sum     = {1'b0, sel_pos} + {3'b000, bus.req_step};
        under   = ({2'b00, bus.req_step} > sel_pos);
        exp_nxt = 4'd0;
        sat_nxt = 1'b0;
        if (bus.req_dir[0]) begin
            exp_nxt = under ? 4'd0 : (sel_pos - {2'b00, bus.req_step});
            sat_nxt = under;
        end else begin
            exp_nxt = sum[4] ? 4'd15 : sum[3:0];
            sat_nxt = sum[4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            x_r       <= HOME_X;
            y_r       <= HOME_Y;
            pos_r     <= 4'd0;
            step_r    <= 2'd0;
            op_r      <= 1'b0;
            sel_y_r   <= 1'b0;
            exp_r     <= 4'd0;
            sat_exp_r <= 1'b0;
            done_r    <= 1'b0;
            sat_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_nxt;
            done_r  <= commit;
            if (accept) begin
                pos_r     <= sel_pos;
                step_r    <= bus.req_step;
                op_r      <= bus.req_dir[0];
                sel_y_r   <= bus.req_dir[1];
                exp_r     <= exp_nxt;
                sat_exp_r <= sat_nxt;
            end
            // The mover's value is committed even when it disagrees with the reference.
            if (commit) begin
                sat_r <= sat_exp_r;
                if (sel_y_r) y_r <= bus.mv_out;
                else         x_r <= bus.mv_out;
                if (bus.mv_out != exp_r) err_r <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_r == IDLE);
    assign bus.mv_pos    = pos_r;
    assign bus.mv_step   = step_r;
    assign bus.mv_op     = op_r;
    assign x             = x_r;
    assign y             = y_r;
    assign done          = done_r;
    assign sat           = sat_r;
    assign err           = err_r;
    assign state_dbg     = state_r;

endmodule

// File: tb/tb_grid_ctrl.sv
// Directed bench for grid_ctrl: a behavioural saturating mover plus hand-computed move vectors.
module tb_grid_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] x, y;
    logic       done, sat, err;
    logic [1:0] state_dbg;

    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'd0;
    logic       err_exp   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    grid_ctrl_if bus ();

    grid_ctrl #(.HOME_X(4'd5), .HOME_Y(4'd9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .x         (x),
        .y         (y),
        .done      (done),
        .sat       (sat),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- mover model (registered, saturating) ----------------
    function automatic logic [3:0] mover_f(input logic [3:0] pos, input logic [1:0] step,
                                           input logic op);
        logic [4:0] s;
        s = {1'b0, pos} + {3'b000, step};
        if (op) return ({2'b00, step} > pos) ? 4'd0 : pos - {2'b00, step};
        else    return (s > 5'd15) ? 4'd15 : s[3:0];
    endfunction

    always @(posedge clk) begin
        if (force_en) bus.mv_out <= force_val;
        else          bus.mv_out <= mover_f(bus.mv_pos, bus.mv_step, bus.mv_op);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge, DUT in IDLE) ----------------
    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        err_exp = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] dir, input logic [1:0] step, input bit hold,
                           input logic [3:0] exp_pos, input logic [3:0] exp_x,
                           input logic [3:0] exp_y, input logic exp_sat);
        bus.req_valid = 1'b1;
        bus.req_dir   = dir;
        bus.req_step  = step;
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        check("issue_state", state_dbg, 1);
        check("issue_ready", bus.req_ready, 0);
        check("issue_pos", bus.mv_pos, exp_pos);
        check("issue_step", bus.mv_step, step);
        check("issue_op", bus.mv_op, dir[0]);
        check("issue_done", done, 0);
        @(negedge clk);
        check("capture_state", state_dbg, 2);
        check("capture_ready", bus.req_ready, 0);
        check("capture_done", done, 0);
        @(negedge clk);
        check("commit_done", done, 1);
        check("commit_x", x, exp_x);
        check("commit_y", y, exp_y);
        check("commit_sat", sat, exp_sat);
        check("commit_err", err, err_exp);
        check("commit_ready", bus.req_ready, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.req_valid = 1'b0;
        bus.req_dir   = 2'b00;
        bus.req_step  = 2'b00;

        // Reset state with HOME_X=5, HOME_Y=9
        do_reset();
        check("rst_x", x, 5);
        check("rst_y", y, 9);
        check("rst_ready", bus.req_ready, 1);
        check("rst_done", done, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err, 0);
        check("rst_mv_pos", bus.mv_pos, 0);
        check("rst_mv_step", bus.mv_step, 0);
        check("rst_mv_op", bus.mv_op, 0);
        check("rst_state", state_dbg, 0);

        // Walk x to 0 (second move clamps: 2-3), then +X 3 from 0
        do_move(2'b01, 2'd3, 1'b0, 4'd5, 4'd2, 4'd9, 1'b0);
        do_move(2'b01, 2'd3, 1'b0, 4'd2, 4'd0, 4'd9, 1'b1);
        do_move(2'b00, 2'd3, 1'b0, 4'd0, 4'd3, 4'd9, 1'b0);
        @(negedge clk);
        check("done_one_pulse", done, 0);
        check("idle_holds_mv_pos", bus.mv_pos, 0);

        // Clamp at the top: 3 -> 14, then 14+3 -> 15 clamped, 15+3 -> 15 clamped
        do_move(2'b00, 2'd3, 1'b0, 4'd3,  4'd6,  4'd9, 1'b0);
        do_move(2'b00, 2'd3, 1'b0, 4'd6,  4'd9,  4'd9, 1'b0);
        do_move(2'b00, 2'd3, 1'b0, 4'd9,  4'd12, 4'd9, 1'b0);
        do_move(2'b00, 2'd2, 1'b0, 4'd12, 4'd14, 4'd9, 1'b0);
        do_move(2'b00, 2'd3, 1'b0, 4'd14, 4'd15, 4'd9, 1'b1);
        do_move(2'b00, 2'd3, 1'b0, 4'd15, 4'd15, 4'd9, 1'b1);
        // Clamp at the bottom: y 9 -> 1, then 1-2 -> 0 clamped
        do_move(2'b11, 2'd3, 1'b0, 4'd9, 4'd15, 4'd6, 1'b0);
        do_move(2'b11, 2'd3, 1'b0, 4'd6, 4'd15, 4'd3, 1'b0);
        do_move(2'b11, 2'd2, 1'b0, 4'd3, 4'd15, 4'd1, 1'b0);
        do_move(2'b11, 2'd2, 1'b0, 4'd1, 4'd15, 4'd0, 1'b1);
        // Exact edges do not clamp: 13+2 -> 15, 2-2 -> 0; step 0 still pulses done
        do_move(2'b01, 2'd2, 1'b0, 4'd15, 4'd13, 4'd0, 1'b0);
        do_move(2'b00, 2'd2, 1'b0, 4'd13, 4'd15, 4'd0, 1'b0);
        do_move(2'b10, 2'd2, 1'b0, 4'd0,  4'd15, 4'd2, 1'b0);
        do_move(2'b11, 2'd2, 1'b0, 4'd2,  4'd15, 4'd0, 1'b0);
        do_move(2'b10, 2'd0, 1'b0, 4'd0,  4'd15, 4'd0, 1'b0);

        // Bring to x=y=4
        do_move(2'b01, 2'd3, 1'b0, 4'd15, 4'd12, 4'd0, 1'b0);
        do_move(2'b01, 2'd3, 1'b0, 4'd12, 4'd9,  4'd0, 1'b0);
        do_move(2'b01, 2'd3, 1'b0, 4'd9,  4'd6,  4'd0, 1'b0);
        do_move(2'b01, 2'd2, 1'b0, 4'd6,  4'd4,  4'd0, 1'b0);
        do_move(2'b10, 2'd3, 1'b0, 4'd0,  4'd4,  4'd3, 1'b0);
        do_move(2'b10, 2'd1, 1'b0, 4'd3,  4'd4,  4'd4, 1'b0);

        // Back-to-back with req_valid held high: one accept every 3 clocks
        do_move(2'b00, 2'd1, 1'b1, 4'd4, 4'd5, 4'd4, 1'b0);
        do_move(2'b10, 2'd2, 1'b1, 4'd4, 4'd5, 4'd6, 1'b0);
        do_move(2'b01, 2'd1, 1'b1, 4'd5, 4'd4, 4'd6, 1'b0);
        do_move(2'b11, 2'd3, 1'b0, 4'd6, 4'd4, 4'd3, 1'b0);
        @(negedge clk);
        check("b2b_done_low", done, 0);
        check("b2b_final_x", x, 4);
        check("b2b_final_y", y, 3);

        // Reset during CAPTURE aborts the move
        bus.req_valid = 1'b1;
        bus.req_dir   = 2'b00;
        bus.req_step  = 2'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_capture", state_dbg, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_x", x, 5);
        check("abort_y", y, 9);
        check("abort_state", state_dbg, 0);
        check("abort_ready", bus.req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_late_done", done, 0);
        check("abort_x_hold", x, 5);

        // Faulty mover: 5-2 should be 3, mover returns 7
        force_en  = 1'b1;
        force_val = 4'd7;
        err_exp   = 1'b1;
        do_move(2'b01, 2'd2, 1'b0, 4'd5, 4'd7, 4'd9, 1'b0);
        force_en  = 1'b0;
        do_move(2'b10, 2'd1, 1'b0, 4'd9, 4'd7, 4'd10, 1'b0);
        do_move(2'b01, 2'd3, 1'b0, 4'd7, 4'd4, 4'd10, 1'b0);
        check("err_sticky", err, 1);
        do_reset();
        check("err_cleared", err, 0);
        check("err_rst_x", x, 5);
        check("err_rst_y", y, 10 - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
